unified_memory_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch path (PC-addressed) and the load/store path (lw/sw).
- Arbitrates the two requesters, sequences each read through a fixed-latency wait, and returns the data to whichever requester owns it.
- Sits between the program counter / instruction register and the data-memory interface, where the CPU moves to a multi-cycle core with one memory.

---
 rtl/unified_memory_arbiter_pkg.sv | 28 ++
 rtl/unified_memory_arbiter_if.sv | 43 ++++
 rtl/unified_memory_arbiter_priority_select.sv | 29 ++
 rtl/unified_memory_arbiter.sv | 135 +++++++++++++
 tb/tb_unified_memory_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_memory_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_memory_arbiter_pkg;

   localparam int CNT_W = 4;

   // Fixed encodings kept identical to the legacy state register values
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE = ST_IDLE,
      ARB_WAIT = ST_WAIT,
      ARB_RESP = ST_RESP
   } arb_state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } arb_owner_t;

   // Increment that sticks at lim instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
      return (v >= lim) ? lim : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/unified_memory_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
interface unified_memory_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch side
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // load/store side
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // control / status
   logic              flush;
   logic              busy;
   // memory side
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // arbiter view
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   // CPU + memory view
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/unified_memory_arbiter_priority_select.sv
// Combinational requester selection: data first, fetch when the data streak
// has hit its limit; a flushed fetch is never selected.
module arb_priority_select (
   input  logic if_req,
   input  logic d_req,
   input  logic flush,
   input  logic streak_max,
   output logic grant_fetch,
   output logic grant_data
);

   logic fetch_ok;

   assign fetch_ok = if_req & ~flush;

   // One-hot (or empty) selection of the winning requester
   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      if (fetch_ok && streak_max) begin
         grant_fetch = 1'b1;
      end else if (d_req) begin
         grant_data = 1'b1;
      end else if (fetch_ok) begin
         grant_fetch = 1'b1;
      end
   end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Grants are combinational in IDLE/RESP; reads wait READ_LATENCY cycles and
// return data to the registered owner in the RESP cycle.
module unified_memory_arbiter
   import unified_memory_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   unified_memory_arbiter_if.slave  bus
);

   arb_state_t        state;
   arb_owner_t        owner;
   logic [CNT_W-1:0]  lat_cnt;
   logic [CNT_W-1:0]  streak_cnt;
   logic              drop;

   logic              streak_max;
   logic              arb_en;
   logic              sel_fetch;
   logic              sel_data;
   logic              gnt_f;
   logic              gnt_d;
   logic              rd_done;
   logic              drop_now;
   logic              mem_we_c;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign streak_max = (streak_cnt == CNT_W'(MAX_D_STREAK));
   // Grants are suppressed while reset is asserted so all strobes read 0
   assign arb_en     = reset && (state != ARB_WAIT);
   assign gnt_f      = arb_en & sel_fetch;
   assign gnt_d      = arb_en & sel_data;
   assign rd_done    = (state == ARB_WAIT) && (lat_cnt == '0);
   // A flush in the final wait cycle must still suppress the response
   assign drop_now   = drop | (bus.flush && (state == ARB_WAIT) && (owner == OWN_FETCH));

   arb_priority_select u_sel (
      .if_req      (bus.if_req),
      .d_req       (bus.d_req),
      .flush       (bus.flush),
      .streak_max  (streak_max),
      .grant_fetch (sel_fetch),
      .grant_data  (sel_data)
   );

   // Memory-side request mux driven from whichever requester is granted
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      mem_we_c  = 1'b0;
      if (gnt_d) begin
         sel_addr  = bus.d_addr;
         sel_wdata = bus.d_wdata;
         mem_we_c  = bus.d_we;
      end else if (gnt_f) begin
         sel_addr  = bus.if_addr;
      end
   end

   assign bus.if_gnt    = gnt_f;
   assign bus.d_gnt     = gnt_d;
   assign bus.mem_en    = gnt_f | gnt_d;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = sel_addr;
   assign bus.mem_wdata = sel_wdata;
   assign bus.busy      = (state == ARB_WAIT);

   // FSM, latency counter, drop flag and response registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= ARB_IDLE;
         owner        <= OWN_FETCH;
         lat_cnt      <= '0;
         drop         <= 1'b0;
         bus.if_rvalid <= 1'b0;
         bus.d_rvalid  <= 1'b0;
         bus.if_rdata  <= '0;
         bus.d_rdata   <= '0;
      end else begin
         bus.if_rvalid <= 1'b0;
         bus.d_rvalid  <= 1'b0;
         case (state)
            ARB_IDLE, ARB_RESP: begin
               if (gnt_f) begin
                  owner   <= OWN_FETCH;
                  state   <= ARB_WAIT;
                  lat_cnt <= CNT_W'(READ_LATENCY - 1);
               end else if (gnt_d && !bus.d_we) begin
                  owner   <= OWN_DATA;
                  state   <= ARB_WAIT;
                  lat_cnt <= CNT_W'(READ_LATENCY - 1);
               end else begin
                  state <= ARB_IDLE;
               end
            end
            ARB_WAIT: begin
               if (rd_done) begin
                  state <= ARB_RESP;
                  drop  <= 1'b0;
                  if (owner == OWN_DATA) begin
                     bus.d_rvalid <= 1'b1;
                     bus.d_rdata  <= bus.mem_rdata;
                  end else if (!drop_now) begin
                     bus.if_rvalid <= 1'b1;
                     bus.if_rdata  <= bus.mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt - CNT_W'(1);
                  drop    <= drop_now;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Consecutive data grants while a fetch waits; cleared when fetch is served or idle
   always_ff @(posedge clock) begin
      if (!reset) begin
         streak_cnt <= '0;
      end else if (!bus.if_req || gnt_f) begin
         streak_cnt <= '0;
      end else if (gnt_d) begin
         streak_cnt <= sat_inc(streak_cnt, CNT_W'(MAX_D_STREAK));
      end
   end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Scoreboard bench: requests push expected responses, negedge monitors pop and compare.
module tb_unified_memory_arbiter;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   int unsigned cyc = 0;
   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   int unsigned if2_pulses = 0;

   exp_t ifq1[$];
   exp_t dq1[$];
   exp_t ifq2[$];
   exp_t dq2[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   unified_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   unified_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

   unified_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .MAX_D_STREAK(4)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (b1)
   );

   unified_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .MAX_D_STREAK(4)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (b2)
   );

   // memory models: preload during reset, latency 1 and latency 3
   logic [31:0] mem1[64];
   logic [31:0] mem2[64];
   logic [31:0] rd1;
   logic [31:0] p2[3];

   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) begin
            mem1[i] <= 32'h1000_0000 + i;
            mem2[i] <= 32'h2000_0000 + i;
         end
         mem1[0] <= 32'hDEAD_BEEF;  mem2[0] <= 32'hDEAD_BEEF;
         mem1[2] <= 32'h0050_0093;  mem2[2] <= 32'h0050_0093;
         mem1[6] <= 32'h1234_5678;  mem2[6] <= 32'h1234_5678;
      end else begin
         if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
         if (b1.mem_en && !b1.mem_we) rd1 <= mem1[b1.mem_addr[7:2]];
         if (b2.mem_en && b2.mem_we) mem2[b2.mem_addr[7:2]] <= b2.mem_wdata;
      end
      p2[0] <= (b2.mem_en && !b2.mem_we) ? mem2[b2.mem_addr[7:2]] : 32'h0;
      p2[1] <= p2[0];
      p2[2] <= p2[1];
   end

   assign b1.mem_rdata = rd1;
   assign b2.mem_rdata = p2[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitors
   exp_t e1, e2;
   always @(negedge clock) begin
      if (b1.if_rvalid) begin
         if (ifq1.size() == 0) check("if1_unexpected_rvalid", 64'(b1.if_rdata), 64'h1_0000_0000);
         else begin
            e1 = ifq1.pop_front();
            check("if1_rdata", 64'(b1.if_rdata), 64'(e1.data));
            check("if1_rvalid_cycle", 64'(cyc), 64'(e1.cyc));
         end
      end
      if (b1.d_rvalid) begin
         if (dq1.size() == 0) check("d1_unexpected_rvalid", 64'(b1.d_rdata), 64'h1_0000_0000);
         else begin
            e1 = dq1.pop_front();
            check("d1_rdata", 64'(b1.d_rdata), 64'(e1.data));
            check("d1_rvalid_cycle", 64'(cyc), 64'(e1.cyc));
         end
      end
      check("one_grant_1", 64'(b1.if_gnt & b1.d_gnt), 64'h0);
      check("no_mem_en_wait_1", 64'(b1.busy & b1.mem_en), 64'h0);
   end

   always @(negedge clock) begin
      if (b2.if_rvalid) begin
         if2_pulses++;
         if (ifq2.size() == 0) check("if2_unexpected_rvalid", 64'(b2.if_rdata), 64'h1_0000_0000);
         else begin
            e2 = ifq2.pop_front();
            check("if2_rdata", 64'(b2.if_rdata), 64'(e2.data));
            check("if2_rvalid_cycle", 64'(cyc), 64'(e2.cyc));
         end
      end
      if (b2.d_rvalid) begin
         if (dq2.size() == 0) check("d2_unexpected_rvalid", 64'(b2.d_rdata), 64'h1_0000_0000);
         else begin
            e2 = dq2.pop_front();
            check("d2_rdata", 64'(b2.d_rdata), 64'(e2.data));
            check("d2_rvalid_cycle", 64'(cyc), 64'(e2.cyc));
         end
      end
      check("no_mem_en_wait_2", 64'(b2.busy & b2.mem_en), 64'h0);
   end

   // request on instance 1 (latency 1); reads push an expectation at grant+2
   task automatic req1(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, output int unsigned gcyc);
      bit got = 1'b0;
      gcyc = 0;
      if (is_d) begin
         b1.d_req = 1'b1; b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wdata;
      end else begin
         b1.if_req = 1'b1; b1.if_addr = addr;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (is_d ? b1.d_gnt : b1.if_gnt) begin
            got  = 1'b1;
            gcyc = cyc;
            check("grant_bus_1", 64'({b1.mem_en, b1.mem_we, b1.mem_addr}), 64'({1'b1, we, addr}));
            if (we) check("grant_wdata_1", 64'(b1.mem_wdata), 64'(wdata));
            else if (is_d) dq1.push_back(exp_t'{data: exp, cyc: cyc + 2});
            else ifq1.push_back(exp_t'{data: exp, cyc: cyc + 2});
         end
      end
      if (!got) check("grant_timeout_1", 64'h0, 64'h1);
      @(posedge clock); #1;
      if (is_d) b1.d_req = 1'b0; else b1.if_req = 1'b0;
   endtask

   // read request on instance 2 (latency 3); expectation at grant+4 unless suppressed
   task automatic req2(input bit is_d, input logic [31:0] addr, input logic [31:0] exp,
                       input bit push, output int unsigned gcyc);
      bit got = 1'b0;
      gcyc = 0;
      if (is_d) begin
         b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = addr;
      end else begin
         b2.if_req = 1'b1; b2.if_addr = addr;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (is_d ? b2.d_gnt : b2.if_gnt) begin
            got  = 1'b1;
            gcyc = cyc;
            check("grant_bus_2", 64'({b2.mem_en, b2.mem_we, b2.mem_addr}), 64'({1'b1, 1'b0, addr}));
            if (push) begin
               if (is_d) dq2.push_back(exp_t'{data: exp, cyc: cyc + 4});
               else ifq2.push_back(exp_t'{data: exp, cyc: cyc + 4});
            end
         end
      end
      if (!got) check("grant_timeout_2", 64'h0, 64'h1);
      @(posedge clock); #1;
      if (is_d) b2.d_req = 1'b0; else b2.if_req = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60; i++) begin
         if (ifq1.size() + dq1.size() + ifq2.size() + dq2.size() == 0) break;
         @(negedge clock);
      end
      check("drain", 64'(ifq1.size() + dq1.size() + ifq2.size() + dq2.size()), 64'h0);
      @(posedge clock); #1;
   endtask

   task automatic check_idle1(input string tag);
      check({tag, "_flags"}, 64'({b1.if_gnt, b1.if_rvalid, b1.d_gnt, b1.d_rvalid,
                                   b1.mem_en, b1.mem_we, b1.busy}), 64'h0);
      check({tag, "_mem_addr"}, 64'(b1.mem_addr), 64'h0);
      check({tag, "_mem_wdata"}, 64'(b1.mem_wdata), 64'h0);
      check({tag, "_if_rdata"}, 64'(b1.if_rdata), 64'h0);
      check({tag, "_d_rdata"}, 64'(b1.d_rdata), 64'h0);
   endtask

   int unsigned g_a, g_b, ng, p_before;
   logic [5:0]  seq;
   bit          fgot;

   initial begin
      reset = 1'b0;
      b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.flush = 0;
      b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0; b2.flush = 0;
      repeat (3) @(posedge clock);
      #1;
      @(negedge clock);
      check_idle1("reset");
      check("reset_flags_2", 64'({b2.if_gnt, b2.if_rvalid, b2.d_gnt, b2.d_rvalid,
                                   b2.mem_en, b2.busy, b2.if_rdata, b2.d_rdata}), 64'h0);
      @(posedge clock); #1;
      reset = 1'b1;

      // single fetch
      req1(1'b0, 1'b0, 32'h08, 32'h0, 32'h0050_0093, g_a);
      wait_drain();

      // simultaneous fetch and load: load first, fetch in the load's RESP cycle
      fork
         req1(1'b0, 1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, g_a);
         req1(1'b1, 1'b0, 32'h18, 32'h0, 32'h1234_5678, g_b);
      join
      check("simul_fetch_in_resp", 64'(g_a), 64'(g_b + 2));
      wait_drain();

      // store then load back-to-back
      req1(1'b1, 1'b1, 32'h18, 32'h0000_002A, 32'h0, g_a);
      req1(1'b1, 1'b0, 32'h18, 32'h0, 32'h0000_002A, g_b);
      check("store_load_consecutive", 64'(g_b), 64'(g_a + 1));
      wait_drain();

      // starvation guard: four stores, then the fetch, then data again
      b1.if_req = 1'b1; b1.if_addr = 32'h08;
      b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h40; b1.d_wdata = 32'h0;
      seq = '0; ng = 0;
      for (int i = 0; i < 30 && ng < 6; i++) begin
         fgot = 1'b0;
         @(negedge clock);
         if (b1.d_gnt) begin
            seq = {seq[4:0], 1'b1}; ng++;
         end else if (b1.if_gnt) begin
            seq = {seq[4:0], 1'b0}; ng++; fgot = 1'b1;
            ifq1.push_back(exp_t'{data: 32'h0050_0093, cyc: cyc + 2});
         end
         @(posedge clock); #1;
         if (fgot) b1.if_req = 1'b0;
         b1.d_wdata = b1.d_wdata + 1;
      end
      b1.d_req = 1'b0; b1.if_req = 1'b0; b1.d_we = 1'b0;
      check("streak_grants", 64'(ng), 64'd6);
      check("streak_pattern", 64'(seq), 64'b111101);
      wait_drain();

      // flush after a fetch grant on the latency-3 instance
      req2(1'b0, 32'h08, 32'h0050_0093, 1'b1, g_a);
      wait_drain();
      p_before = if2_pulses;
      req2(1'b0, 32'h00, 32'h0, 1'b0, g_a);
      b2.flush = 1'b1;
      @(negedge clock);
      check("flush_busy", 64'(b2.busy), 64'h1);
      @(posedge clock); #1;
      b2.flush = 1'b0;
      repeat (8) @(negedge clock);
      check("flush_no_rvalid", 64'(if2_pulses), 64'(p_before));
      check("flush_rdata_held", 64'(b2.if_rdata), 64'h0050_0093);
      @(posedge clock); #1;
      req2(1'b1, 32'h18, 32'h1234_5678, 1'b1, g_b);
      wait_drain();

      // reset during the WAIT of a load
      b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h08;
      @(negedge clock);
      check("rst_load_gnt", 64'(b1.d_gnt), 64'h1);
      @(posedge clock); #1;
      b1.d_req = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      check("rst_in_wait", 64'(b1.busy), 64'h1);
      @(posedge clock); #1;
      @(negedge clock);
      check_idle1("rst_abort");
      @(posedge clock); #1;
      reset = 1'b1;
      req1(1'b0, 1'b0, 32'h08, 32'h0, 32'h0050_0093, g_a);
      wait_drain();

      repeat (4) @(negedge clock);
      check("final_queues_empty", 64'(ifq1.size() + dq1.size() + ifq2.size() + dq2.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
